// File: rtl/i2c_slave_regif_if.sv
// rtl/i2c_slave_regif_if.sv - I2C pins, register port and status bundle for i2c_slave_regif
interface i2c_slave_regif_if #(
  parameter int PTR_W = 4
);
  logic             scl_in;
  logic             sda_in;
  logic             scl_oe;
  logic             sda_oe;
  logic [6:0]       slave_addr;
  logic             reg_wr_en;
  logic [PTR_W-1:0] reg_wr_addr;
  logic [7:0]       reg_wr_data;
  logic [PTR_W-1:0] reg_rd_addr;
  logic [7:0]       reg_rd_data;
  logic             busy;
  logic             addr_match;
  logic             stop_det;

  modport slave (
    input  scl_in, sda_in, slave_addr, reg_rd_data,
    output scl_oe, sda_oe, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
           busy, addr_match, stop_det
  );

  modport master (
    output scl_in, sda_in, slave_addr, reg_rd_data,
    input  scl_oe, sda_oe, reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_addr,
           busy, addr_match, stop_det
  );
endinterface

// File: rtl/i2c_slave_regif.sv
// rtl/i2c_slave_regif.sv - I2C slave exposing a byte register file through a pointer
// Write: addr+W, pointer byte, data bytes. Read: addr+R streams from the pointer.
module i2c_slave_regif #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH_CYC = 0
) (
  input  logic              clk,
  input  logic              reset,
  i2c_slave_regif_if.slave  bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_IGNORE
  } state_t;

  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic [7:0]             r_sh;
  logic [3:0]             r_bit_cnt;
  logic                   r_rw;
  logic [7:0]             r_tx;
  logic                   r_mack;
  logic [PTR_W-1:0]       r_ptr;
  logic                   r_wr_en;
  logic [PTR_W-1:0]       r_wr_addr;
  logic [7:0]             r_wr_data;
  logic                   r_sda_oe;
  logic                   r_scl_oe;
  logic [15:0]            r_st_cnt;
  logic                   r_busy;
  logic                   r_match;
  logic                   r_stop_det;

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_start, w_stop, w_ack_end;

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  // ACK slot closes and the transaction carries on (a read NACK drops to IGNORE instead)
  assign w_ack_end  = w_scl_fall && ((r_state == S_ADDR_ACK) || (r_state == S_PTR_ACK) ||
                                     (r_state == S_WR_ACK) || (r_state == S_RD_ACK && !r_mack));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], bus.sda_in};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_sh       <= 8'd0;
      r_bit_cnt  <= 4'd0;
      r_rw       <= 1'b0;
      r_tx       <= 8'd0;
      r_mack     <= 1'b1;
      r_ptr      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= 8'd0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_match    <= 1'b0;
      r_stop_det <= 1'b0;
    end else begin
      r_wr_en    <= 1'b0;
      r_stop_det <= 1'b0;
      if (w_stop) begin
        r_state    <= S_IDLE;
        r_sda_oe   <= 1'b0;
        r_busy     <= 1'b0;
        r_match    <= 1'b0;
        r_stop_det <= 1'b1;
      end else if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_sda_oe  <= 1'b0;
        r_busy    <= 1'b1;
        r_match   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR, S_PTR, S_WR: begin
            if (w_scl_rise && r_bit_cnt != 4'd8) begin
              r_sh      <= {r_sh[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (r_state == S_ADDR) begin
                if (r_sh[7:1] == bus.slave_addr) begin
                  r_state  <= S_ADDR_ACK;
                  r_sda_oe <= 1'b1;
                  r_match  <= 1'b1;
                  r_rw     <= r_sh[0];
                end else begin
                  r_state <= S_IGNORE;
                  r_match <= 1'b0;
                end
              end else if (r_state == S_PTR) begin
                r_ptr    <= r_sh[PTR_W-1:0];
                r_sda_oe <= 1'b1;
                r_state  <= S_PTR_ACK;
              end else begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_ptr;
                r_wr_data <= r_sh;
                r_ptr     <= r_ptr + 1'b1;
                r_sda_oe  <= 1'b1;
                r_state   <= S_WR_ACK;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (r_rw) begin
                r_state  <= S_RD;
                r_tx     <= bus.reg_rd_data;
                r_sda_oe <= ~bus.reg_rd_data[7];
              end else begin
                r_state  <= S_PTR;
                r_sda_oe <= 1'b0;
              end
            end
          end
          S_PTR_ACK, S_WR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              r_sda_oe  <= 1'b0;
              r_state   <= S_WR;
            end
          end
          S_RD: begin
            if (w_scl_fall) begin
              if (r_bit_cnt == 4'd7) begin
                r_bit_cnt <= 4'd0;
                r_sda_oe  <= 1'b0;
                r_state   <= S_RD_ACK;
              end else begin
                r_tx      <= {r_tx[6:0], 1'b0};
                r_sda_oe  <= ~r_tx[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RD_ACK: begin
            // Advance on the ACK rise so reg_rd_data already reflects the next register at the fall
            if (w_scl_rise) begin
              r_mack <= w_sda;
              if (!w_sda) r_ptr <= r_ptr + 1'b1;
            end else if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
              if (!r_mack) begin
                r_state  <= S_RD;
                r_tx     <= bus.reg_rd_data;
                r_sda_oe <= ~bus.reg_rd_data[7];
              end else begin
                r_state  <= S_IGNORE;
                r_sda_oe <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_oe <= 1'b0;
      r_st_cnt <= 16'd0;
    end else if (w_start || w_stop) begin
      r_scl_oe <= 1'b0;
      r_st_cnt <= 16'd0;
    end else if (w_ack_end && STRETCH_CYC > 0) begin
      r_scl_oe <= 1'b1;
      r_st_cnt <= 16'(STRETCH_CYC - 1);
    end else if (r_scl_oe) begin
      if (r_st_cnt == 16'd0) r_scl_oe <= 1'b0;
      else                   r_st_cnt <= r_st_cnt - 16'd1;
    end
  end

  assign bus.scl_oe      = r_scl_oe;
  assign bus.sda_oe      = r_sda_oe;
  assign bus.reg_wr_en   = r_wr_en;
  assign bus.reg_wr_addr = r_wr_addr;
  assign bus.reg_wr_data = r_wr_data;
  assign bus.reg_rd_addr = r_ptr;
  assign bus.busy        = r_busy;
  assign bus.addr_match  = r_match;
  assign bus.stop_det    = r_stop_det;
endmodule

// File: doc/i2c_slave_regif.md
I2C_SLAVE_REGIF -- requirements
Module: i2c_slave_regif

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning number of byte registers addressable (power of two, 2..256).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchroniser flops on scl_in/sda_in (>=2).
REQ-003 SHALL have parameter STRETCH_CYC, default 0, meaning clk cycles SCL is held low after each ACK slot (0 = no stretching).
REQ-004 SHALL derive PTR_W = clog2(DEPTH), not user-settable.
REQ-005 clk  input  1  single system clock, all logic on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 scl_in  input  1  SCL level from bus.
REQ-008 sda_in  input  1  SDA level from bus.
REQ-009 scl_oe  output  1  1 = pull SCL low (open-drain enable).
REQ-010 sda_oe  output  1  1 = pull SDA low (open-drain enable).
REQ-011 slave_addr  input  7  own 7-bit address, static during a transaction.
REQ-012 reg_wr_en  output  1  one-clk write strobe.
REQ-013 reg_wr_addr  output  PTR_W  write register index.
REQ-014 reg_wr_data  output  8  write data byte.
REQ-015 reg_rd_addr  output  PTR_W  read register index (current pointer).
REQ-016 reg_rd_data  input  8  user data for reg_rd_addr, valid same cycle.
REQ-017 busy  output  1  1 from START to STOP on bus.
REQ-018 addr_match  output  1  1 while in an addressed transaction.
REQ-019 stop_det  output  1  one-clk pulse on STOP.

Function
REQ-020 SHALL detect edges/START/STOP only on synchronised signals; START = SDA fall while SCL high, STOP = SDA rise while SCL high, valid in any state.
REQ-021 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR, WR_ACK, RD, RD_ACK, IGNORE; START from any state -> ADDR (repeated start), STOP from any state -> IDLE.
REQ-022 ADDR SHALL shift 8 bits MSB-first on SCL rise; on 8th-bit SCL fall, match of bits[7:1] to slave_addr -> ADDR_ACK with sda_oe=1, mismatch -> IGNORE with sda_oe=0.
REQ-023 ADDR_ACK SHALL exit on SCL fall ending 9th clock: R/W=0 -> PTR, R/W=1 -> RD with byte reg_rd_data captured that cycle.
REQ-024 PTR SHALL receive one byte, ACK it, load pointer with byte[PTR_W-1:0] (upper bits ignored), then -> WR.
REQ-025 WR SHALL receive byte, ACK it; on 8th-bit SCL fall pulse reg_wr_en one clk with reg_wr_addr=pointer, reg_wr_data=byte, then pointer increments.
REQ-026 RD SHALL drive byte MSB-first, each bit changed on SCL fall (sda_oe = ~bit); after 8th bit release SDA and sample master ACK on SCL rise in RD_ACK.
REQ-027 RD_ACK: ACK -> pointer increments, next byte captured from reg_rd_data at SCL fall, -> RD; NACK -> IGNORE, SDA released.
REQ-028 Pointer SHALL wrap DEPTH-1 -> 0; SHALL persist across repeated START and STOP; reset to 0.
REQ-029 reg_rd_addr SHALL equal the pointer at all times.
REQ-030 If STRETCH_CYC>0, scl_oe SHALL assert on the SCL fall ending each ACK slot of an addressed transaction and deassert exactly STRETCH_CYC clk cycles later; STOP/START or reset releases it immediately.
REQ-031 IGNORE SHALL keep sda_oe=0 and scl_oe=0 until START/STOP.
REQ-032 addr_match SHALL set on address match, clear on STOP, START or mismatch.
REQ-033 busy SHALL set on START, clear on STOP; stop_det SHALL pulse on every STOP.
REQ-034 STOP mid-byte SHALL discard the partial byte, no reg_wr_en.

Reset
REQ-035 reset SHALL asynchronously force IDLE, pointer=0, synchronisers to 1, scl_oe=0, sda_oe=0, reg_wr_en=0, reg_wr_data=0, busy=0, addr_match=0, stop_det=0.
REQ-036 Reset mid-transaction SHALL release both lines within the same cycle; first post-reset action requires a new START.

Verification
REQ-037 slave_addr=0x42, write 0x84,0x05,0xAA,0xBB,STOP -> ACKs all, reg_wr_en at addr 5 data 0xAA, addr 6 data 0xBB, stop_det pulse.
REQ-038 DEPTH=16, pointer=0x0F, read 2 bytes (ACK,NACK) -> reg_rd_addr 15 then 0, bytes match reg_rd_data, SDA released after NACK.
REQ-039 Address 0x43 sent to slave_addr=0x42 -> no ACK, sda_oe/scl_oe stay 0, addr_match 0, no strobes.
REQ-040 STRETCH_CYC=20, write byte -> scl_oe high exactly 20 clk after ACK-ending SCL fall.
REQ-041 Write pointer 0x03, repeated START, read 1 byte -> reg_rd_addr=3 returned.
REQ-042 reset asserted during RD bit 4 -> sda_oe=0, scl_oe=0 immediately; pointer=0 after.
